// File: rtl/game_state_ctrl.sv
// Game session controller: MENU -> PLAY -> OVER -> MENU sequencing with
// start-edge game selection, tick-based play timeout and a timed OVER hold.
module game_state_ctrl #(
  parameter int unsigned NUM_GAMES     = 3,
  parameter int unsigned GAME_W        = 4,
  parameter int unsigned TIMEOUT_TICKS = 600,
  parameter int unsigned HOLD_TICKS    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_start,
  input  logic              game_finish,
  input  logic [GAME_W-1:0] game_id_in,
  input  logic              tick,
  output logic [1:0]        game_select,
  output logic [GAME_W-1:0] active_game,
  output logic [15:0]       play_ticks,
  output logic              timed_out,
  output logic              state_pulse
);

  typedef enum logic [1:0] {
    S_MENU = 2'b01,
    S_PLAY = 2'b10,
    S_OVER = 2'b11
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_TICKS);
  localparam logic [15:0] HOLD_LIM    = 16'(HOLD_TICKS);
  localparam bit          TIMEOUT_EN  = (TIMEOUT_TICKS != 0);

  state_t      state, state_next;
  logic        start_prev;
  logic        start_edge;
  logic        id_valid;
  logic        start_accept;
  logic        timeout_hit;
  logic        timeout_exit;
  logic [15:0] play_ticks_inc;
  logic [15:0] hold_cnt;
  logic [15:0] hold_inc;

  // start_prev resets high so a start level held through reset is not an edge
  assign start_edge     = game_start & ~start_prev;
  assign id_valid       = (32'(game_id_in) < NUM_GAMES);
  assign play_ticks_inc = (play_ticks == 16'hFFFF) ? play_ticks : play_ticks + 16'd1;
  assign hold_inc       = hold_cnt + 16'd1;
  assign timeout_hit    = TIMEOUT_EN && tick && (play_ticks_inc == TIMEOUT_LIM);
  assign game_select    = state;

  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    timeout_exit = 1'b0;
    case (state)
      S_MENU: begin
        if (start_edge && id_valid) begin
          state_next   = S_PLAY;
          start_accept = 1'b1;
        end
      end
      S_PLAY: begin
        // A finish in the same cycle as the timeout tick takes priority
        if (game_finish) begin
          state_next = S_OVER;
        end else if (timeout_hit) begin
          state_next   = S_OVER;
          timeout_exit = 1'b1;
        end
      end
      S_OVER: begin
        if (tick && (hold_inc == HOLD_LIM)) begin
          state_next = S_MENU;
        end
      end
      default: state_next = S_MENU;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_MENU;
      state_pulse <= 1'b0;
      start_prev  <= 1'b1;
    end else begin
      state       <= state_next;
      state_pulse <= (state_next != state);
      start_prev  <= game_start;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_game <= '0;
      play_ticks  <= '0;
      timed_out   <= 1'b0;
    end else if (start_accept) begin
      active_game <= game_id_in;
      play_ticks  <= '0;
      timed_out   <= 1'b0;
    end else if (state == S_PLAY) begin
      if (tick) begin
        play_ticks <= play_ticks_inc;
      end
      if (timeout_exit) begin
        timed_out <= 1'b1;
      end
    end
  end

  // Held at zero throughout PLAY so it is already clear on entry to OVER
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == S_PLAY) begin
      hold_cnt <= '0;
    end else if ((state == S_OVER) && tick) begin
      hold_cnt <= hold_inc;
    end
  end

endmodule
